// File: rtl/trig_gate_pkg.sv
// trig_gate_pkg
// Shared types and constants for the trigger conditioning stage.
//   state_t        : gate FSM states (LOW, HIGH, BLOCK)
//   FILT_W_DEFAULT : default width of FILTER and the stability counter
//   HOLD_W_DEFAULT : default width of HOLDOFF and the holdoff counter
//   CNT_MAX        : saturation value of the 32-bit statistics counters
//   sat_inc()      : saturating increment for the statistics counters
package trig_gate_pkg;

    localparam int FILT_W_DEFAULT = 16;
    localparam int HOLD_W_DEFAULT = 32;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        HIGH  = 2'd1,
        BLOCK = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/trig_gate_if.sv
// trig_gate_if
// Bundles the trigger, enable, register and result signals of trig_gate.
//   trig_i       : raw trigger level
//   enable_i     : block enable
//   FILTER       : extra stable cycles required before the filtered level changes
//   FILTER_WSTB  : write strobe for FILTER
//   HOLDOFF      : minimum spacing between out_o rising edges (0 = none)
//   HOLDOFF_WSTB : write strobe for HOLDOFF
//   out_o        : conditioned trigger level
//   ACCEPTED     : accepted rising edges   (only with TRIG_GATE_STATS_EN)
//   REJECTED     : holdoff-rejected edges  (only with TRIG_GATE_STATS_EN)
// Modports: master drives the inputs (register/bus side), slave is trig_gate.
// Optional feature macro: TRIG_GATE_STATS_EN.
interface trig_gate_if
    import trig_gate_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEFAULT,
    parameter int HOLD_W = HOLD_W_DEFAULT
);

    logic              trig_i;
    logic              enable_i;
    logic [FILT_W-1:0] FILTER;
    logic              FILTER_WSTB;
    logic [HOLD_W-1:0] HOLDOFF;
    logic              HOLDOFF_WSTB;
    logic              out_o;
`ifdef TRIG_GATE_STATS_EN
    logic [31:0]       ACCEPTED;
    logic [31:0]       REJECTED;

    modport master (
        output trig_i, enable_i, FILTER, FILTER_WSTB, HOLDOFF, HOLDOFF_WSTB,
        input  out_o, ACCEPTED, REJECTED
    );

    modport slave (
        input  trig_i, enable_i, FILTER, FILTER_WSTB, HOLDOFF, HOLDOFF_WSTB,
        output out_o, ACCEPTED, REJECTED
    );
`else
    modport master (
        output trig_i, enable_i, FILTER, FILTER_WSTB, HOLDOFF, HOLDOFF_WSTB,
        input  out_o
    );

    modport slave (
        input  trig_i, enable_i, FILTER, FILTER_WSTB, HOLDOFF, HOLDOFF_WSTB,
        output out_o
    );
`endif

endinterface

// File: rtl/trig_filter.sv
// trig_filter
// Debounce for a single-bit level: dout changes only after din has differed
// from it on FILTER+1 consecutive sampling edges; shorter glitches vanish.
//   clk_i       : clock (rising edge)
//   reset_i     : synchronous reset, active-high
//   din         : raw level
//   FILTER      : extra stable cycles required before dout changes
//   FILTER_WSTB : restarts the stability count; dout is kept
//   dout        : filtered level (registered)
module trig_filter
    import trig_gate_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              din,
    input  logic [FILT_W-1:0] FILTER,
    input  logic              FILTER_WSTB,
    output logic              dout
);

    logic              filt;
    logic [FILT_W-1:0] stab_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt     <= 1'b0;
            stab_cnt <= '0;
        end else if (FILTER_WSTB) begin
            stab_cnt <= '0;
        end else if (din != filt) begin
            if (stab_cnt == FILTER) begin
                filt     <= ~filt;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end else begin
            stab_cnt <= '0;
        end
    end

    assign dout = filt;

endmodule

// File: rtl/trig_gate.sv
// trig_gate
// Trigger conditioning ahead of the pulse block: glitch-filters trig_i and
// enforces a minimum spacing between accepted rising edges of out_o.
//   clk_i   : clock (rising edge)
//   reset_i : synchronous reset, active-high
//   bus     : trig_gate_if.slave (trig_i, enable_i, FILTER/HOLDOFF registers
//             and strobes, out_o, optional ACCEPTED/REJECTED)
// Optional feature macro: TRIG_GATE_STATS_EN adds the ACCEPTED/REJECTED
// counters (32-bit, saturating, cleared on enable_i rising).
module trig_gate
    import trig_gate_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEFAULT,
    parameter int HOLD_W = HOLD_W_DEFAULT
) (
    input logic        clk_i,
    input logic        reset_i,
    trig_gate_if.slave bus
);

    logic              filt;
    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [HOLD_W-1:0] hold_load;
    logic              accept;
    logic              reject;

    trig_filter #(
        .FILT_W (FILT_W)
    ) u_filter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .din         (bus.trig_i),
        .FILTER      (bus.FILTER),
        .FILTER_WSTB (bus.FILTER_WSTB),
        .dout        (filt)
    );

    // The counter is checked for zero on the edge *before* it would reach
    // zero again, so loading HOLDOFF-1 lets a rise at exactly r+HOLDOFF pass.
    // This also makes HOLDOFF=1 behave like HOLDOFF=0.
    assign hold_load = (bus.HOLDOFF == '0) ? '0 : bus.HOLDOFF - 1'b1;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        hold_nxt  = (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;

        case (state)
            LOW: begin
                if (filt) begin
                    if (hold_cnt == '0) begin
                        state_nxt = HIGH;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = BLOCK;
                        reject    = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!filt) state_nxt = LOW;
            end
            BLOCK: begin
                // Edge already refused; wait for the level to fall first.
                if (!filt) state_nxt = LOW;
            end
            default: state_nxt = LOW;
        endcase

        if (accept) hold_nxt = hold_load;

        if (bus.HOLDOFF_WSTB) hold_nxt = '0;

        // Disable overrides everything except reset; the filter keeps running.
        if (!bus.enable_i) begin
            state_nxt = LOW;
            accept    = 1'b0;
            reject    = 1'b0;
            hold_nxt  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= LOW;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Decoded straight from the state register, so out_o is glitch-free.
    assign bus.out_o = (state == HIGH);

`ifdef TRIG_GATE_STATS_EN
    logic        enable_q;
    logic [31:0] accepted;
    logic [31:0] rejected;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            enable_q <= 1'b0;
            accepted <= '0;
            rejected <= '0;
        end else begin
            enable_q <= bus.enable_i;
            if (bus.enable_i && !enable_q) begin
                // Clear on enable rising, still counting an event on that edge.
                accepted <= accept ? 32'd1 : 32'd0;
                rejected <= reject ? 32'd1 : 32'd0;
            end else begin
                if (accept) accepted <= sat_inc(accepted);
                if (reject) rejected <= sat_inc(rejected);
            end
        end
    end

    assign bus.ACCEPTED = accepted;
    assign bus.REJECTED = rejected;
`endif

endmodule

// File: tb/tb_trig_gate.sv
// tb_trig_gate
// Directed stimulus for trig_gate with a scoreboard: each phase pushes its
// hand-computed expectations (edge number, signal, value) into a queue and an
// independent monitor compares them on the falling edge after that edge.
// Statistics checks are included when TRIG_GATE_STATS_EN is defined.
module tb_trig_gate;
    import trig_gate_pkg::*;

    localparam int K_OUT = 0;
    localparam int K_ACC = 1;
    localparam int K_REJ = 2;

    typedef struct {
        string       name;
        int          edge_no;
        int          kind;
        logic [31:0] value;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_n = 0;
    int   base   = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    trig_gate_if tgif ();

    trig_gate dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (tgif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] actual_of(input int kind);
        logic [31:0] v;
        v = {31'b0, tgif.out_o};
`ifdef TRIG_GATE_STATS_EN
        if (kind == K_ACC) v = tgif.ACCEPTED;
        if (kind == K_REJ) v = tgif.REJECTED;
`endif
        return v;
    endfunction

    // Monitor: compares every expectation due at the edge just taken.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].edge_no < edge_n) begin
                check({sb[i].name, "_missed"}, 32'd1, 32'd0);
                sb.delete(i);
            end else if (sb[i].edge_no == edge_n) begin
                check(sb[i].name, actual_of(sb[i].kind), sb[i].value);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int k, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.name    = nm;
        e.edge_no = base + k;
        e.kind    = kind;
        e.value   = v;
        sb.push_back(e);
    endtask

    task automatic exp_out(input int k, input logic v, input string nm);
        expect_at(k, K_OUT, {31'b0, v}, nm);
    endtask

    // Returns at the falling edge just before edge base+k; inputs set
    // afterwards are sampled on edge base+k.
    task automatic goto(input int k);
        while (edge_n < base + k - 1) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] f, input logic [31:0] h);
        @(negedge clk);
        reset              = 1'b1;
        tgif.trig_i        = 1'b0;
        tgif.enable_i      = 1'b0;
        tgif.FILTER        = f;
        tgif.FILTER_WSTB   = 1'b0;
        tgif.HOLDOFF       = h;
        tgif.HOLDOFF_WSTB  = 1'b0;
        @(negedge clk);
        reset         = 1'b0;
        tgif.enable_i = 1'b1;
        base          = edge_n;
    endtask

    initial begin
        reset = 1'b1;

        // Passthrough, FILTER=0 HOLDOFF=0: two-edge latency.
        do_reset(16'd0, 32'd0);
        exp_out(1, 1'b0, "p1_reset_out");
        exp_out(10, 1'b0, "p1_out_e10");
        exp_out(11, 1'b1, "p1_out_e11");
        exp_out(20, 1'b1, "p1_out_e20");
        exp_out(21, 1'b0, "p1_out_e21");
`ifdef TRIG_GATE_STATS_EN
        expect_at(1, K_ACC, 32'd0, "p1_reset_acc");
        expect_at(1, K_REJ, 32'd0, "p1_reset_rej");
        expect_at(11, K_ACC, 32'd1, "p1_acc_e11");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(20); tgif.trig_i = 1'b0;
        goto(23);

        // Glitch reject with FILTER=3.
        do_reset(16'd3, 32'd0);
        exp_out(12, 1'b0, "p2_glitch_e12");
        exp_out(14, 1'b0, "p2_glitch_e14");
        exp_out(16, 1'b0, "p2_glitch_e16");
        exp_out(33, 1'b0, "p2_held_e33");
        exp_out(34, 1'b1, "p2_held_e34");
`ifdef TRIG_GATE_STATS_EN
        expect_at(34, K_ACC, 32'd1, "p2_acc_e34");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(13); tgif.trig_i = 1'b0;
        goto(30); tgif.trig_i = 1'b1;
        goto(36);

        // Holdoff=10: second rise at r+HOLDOFF is accepted.
        do_reset(16'd0, 32'd10);
        exp_out(11, 1'b1, "p3a_out_e11");
        exp_out(15, 1'b0, "p3a_out_e15");
        exp_out(20, 1'b0, "p3a_out_e20");
        exp_out(21, 1'b1, "p3a_out_e21");
`ifdef TRIG_GATE_STATS_EN
        expect_at(21, K_ACC, 32'd2, "p3a_acc_e21");
        expect_at(21, K_REJ, 32'd0, "p3a_rej_e21");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(14); tgif.trig_i = 1'b0;
        goto(20); tgif.trig_i = 1'b1;
        goto(23);

        // Holdoff=10: rise one edge early is rejected and blocked until low.
        do_reset(16'd0, 32'd10);
        exp_out(11, 1'b1, "p3b_out_e11");
        exp_out(15, 1'b0, "p3b_out_e15");
        exp_out(20, 1'b0, "p3b_rej_out_e20");
        exp_out(22, 1'b0, "p3b_block_e22");
        exp_out(24, 1'b0, "p3b_low_e24");
        exp_out(28, 1'b1, "p3b_out_e28");
`ifdef TRIG_GATE_STATS_EN
        expect_at(20, K_REJ, 32'd1, "p3b_rej_e20");
        expect_at(20, K_ACC, 32'd1, "p3b_acc_e20");
        expect_at(28, K_ACC, 32'd2, "p3b_acc_e28");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(14); tgif.trig_i = 1'b0;
        goto(19); tgif.trig_i = 1'b1;
        goto(23); tgif.trig_i = 1'b0;
        goto(27); tgif.trig_i = 1'b1;
        goto(30);

        // Enable drop while high, re-enable with trig_i still high.
        do_reset(16'd0, 32'd0);
        exp_out(11, 1'b1, "p4_out_e11");
        exp_out(13, 1'b0, "p4_out_e13");
        exp_out(15, 1'b1, "p4_out_e15");
        exp_out(17, 1'b1, "p4_out_e17");
        exp_out(18, 1'b0, "p4_dis_e18");
        exp_out(21, 1'b0, "p4_dis_e21");
        exp_out(22, 1'b1, "p4_reen_e22");
        exp_out(24, 1'b1, "p4_out_e24");
`ifdef TRIG_GATE_STATS_EN
        expect_at(15, K_ACC, 32'd2, "p4_acc_e15");
        expect_at(21, K_ACC, 32'd2, "p4_acc_dis_e21");
        expect_at(22, K_ACC, 32'd1, "p4_acc_clr_e22");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(12); tgif.trig_i = 1'b0;
        goto(14); tgif.trig_i = 1'b1;
        goto(18); tgif.enable_i = 1'b0;
        goto(22); tgif.enable_i = 1'b1;
        goto(25);

        // Reset during holdoff with stab_cnt=2; new trigger accepted at once.
        do_reset(16'd3, 32'd10);
        exp_out(14, 1'b1, "p5_out_e14");
        exp_out(16, 1'b1, "p5_out_e16");
        exp_out(17, 1'b0, "p5_rst_out_e17");
        exp_out(21, 1'b0, "p5_out_e21");
        exp_out(22, 1'b1, "p5_out_e22");
`ifdef TRIG_GATE_STATS_EN
        expect_at(17, K_ACC, 32'd0, "p5_rst_acc_e17");
        expect_at(17, K_REJ, 32'd0, "p5_rst_rej_e17");
        expect_at(22, K_ACC, 32'd1, "p5_acc_e22");
        expect_at(22, K_REJ, 32'd0, "p5_rej_e22");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(15); tgif.trig_i = 1'b0;
        goto(17); reset = 1'b1;
        goto(18); reset = 1'b0; tgif.trig_i = 1'b1;
        goto(25);

        // Strobes: HOLDOFF_WSTB frees the holdoff, FILTER_WSTB restarts the count.
        do_reset(16'd0, 32'd10);
        exp_out(11, 1'b1, "p6_out_e11");
        exp_out(13, 1'b0, "p6_out_e13");
        exp_out(16, 1'b1, "p6_hwstb_e16");
        exp_out(24, 1'b1, "p6_fwstb_e24");
        exp_out(26, 1'b1, "p6_fwstb_e26");
        exp_out(27, 1'b0, "p6_fwstb_e27");
`ifdef TRIG_GATE_STATS_EN
        expect_at(16, K_ACC, 32'd2, "p6_acc_e16");
        expect_at(16, K_REJ, 32'd0, "p6_rej_e16");
`endif
        goto(10); tgif.trig_i = 1'b1;
        goto(12); tgif.trig_i = 1'b0;
        goto(14); tgif.HOLDOFF_WSTB = 1'b1;
        goto(15); tgif.HOLDOFF_WSTB = 1'b0; tgif.trig_i = 1'b1;
        goto(18); tgif.FILTER = 16'd3; tgif.FILTER_WSTB = 1'b1;
        goto(19); tgif.FILTER_WSTB = 1'b0;
        goto(20); tgif.trig_i = 1'b0;
        goto(22); tgif.FILTER_WSTB = 1'b1;
        goto(23); tgif.FILTER_WSTB = 1'b0;
        goto(30);

        @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
